// File: rtl/tinycore_ram_loader.sv
// tinycore_ram_loader: framed byte-stream boot loader that writes 16-bit words to RAM and verifies a checksum
module tinycore_ram_loader #(
  parameter int DATA_SZ   = 16,
  parameter int ADDR_SZ   = 16,
  parameter int RAM_SZ    = 1024,
  parameter int BASE_ADDR = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [7:0]         byte_i,
  input  logic               byte_valid_i,
  output logic               byte_ready_o,
  output logic [ADDR_SZ-1:0] ram_addr_o,
  output logic [DATA_SZ-1:0] ram_data_o,
  output logic               ram_we_o,
  output logic               core_rst_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o,
  output logic [15:0]        checksum_o
);
  typedef enum logic [3:0] {IDLE, HDR_L, HDR_H, DATA_L, DATA_H, CSUM_L, CSUM_H, DONE, ERROR} state_t;
  localparam logic [31:0] RAM_MAX = RAM_SZ;
  state_t state;
  logic [15:0] n, idx, sum, word;
  logic [7:0] low;
  logic xfer;
  assign word = {byte_i, low};
  assign byte_ready_o = state inside {[HDR_L:CSUM_H]};
  assign busy_o = byte_ready_o;
  assign xfer = byte_valid_i && byte_ready_o;
  assign done_o = state == DONE;
  assign err_o = state == ERROR;
  assign core_rst_o = state != DONE;
  assign checksum_o = sum;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      n <= '0;
      idx <= '0;
      sum <= '0;
      low <= '0;
      ram_addr_o <= '0;
      ram_data_o <= '0;
      ram_we_o <= 1'b0;
    end else begin
      ram_we_o <= 1'b0;
      case (state)
        IDLE, DONE, ERROR: if (start_i) begin
          state <= HDR_L;
          idx <= '0;
          sum <= '0;
        end
        HDR_L: if (xfer) begin
          low <= byte_i;
          state <= HDR_H;
        end
        HDR_H: if (xfer) begin
          n <= word;
          state <= (word == 16'd0 || 32'(word) > RAM_MAX) ? ERROR : DATA_L;
        end
        DATA_L: if (xfer) begin
          low <= byte_i;
          state <= DATA_H;
        end
        DATA_H: if (xfer) begin
          ram_data_o <= DATA_SZ'(word);
          ram_addr_o <= ADDR_SZ'(BASE_ADDR) + ADDR_SZ'(idx);
          ram_we_o <= 1'b1;
          sum <= sum + word;
          idx <= idx + 16'd1;
          state <= (idx + 16'd1 == n) ? CSUM_L : DATA_L;
        end
        CSUM_L: if (xfer) begin
          low <= byte_i;
          state <= CSUM_H;
        end
        CSUM_H: if (xfer) state <= (word == sum) ? DONE : ERROR;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_tinycore_ram_loader.sv
// tb_tinycore_ram_loader: directed self-checking bench for the RAM loader
module tb_tinycore_ram_loader;
  logic clk = 1'b0, rst = 1'b0, start_i = 1'b0, byte_valid_i = 1'b0;
  logic [7:0] byte_i = '0;
  logic byte_ready_o, ram_we_o, core_rst_o, busy_o, done_o, err_o;
  logic [15:0] ram_addr_o, ram_data_o, checksum_o;
  int compared = 0, mismatched = 0, we_cnt = 0;

  tinycore_ram_loader dut (
    .clk(clk), .rst(rst), .start_i(start_i), .byte_i(byte_i), .byte_valid_i(byte_valid_i),
    .byte_ready_o(byte_ready_o), .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o),
    .ram_we_o(ram_we_o), .core_rst_o(core_rst_o), .busy_o(busy_o), .done_o(done_o),
    .err_o(err_o), .checksum_o(checksum_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (ram_we_o) we_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int t = 0;
    byte_i = b;
    byte_valid_i = 1'b1;
    while (!byte_ready_o && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 20) chk("ready_timeout", 32'(t), 32'd0);
    @(posedge clk); #1;
    byte_valid_i = 1'b0;
    repeat (gap) @(posedge clk);
    if (gap > 0) #1;
  endtask

  task automatic write_chk(input string tag, input logic [15:0] a, input logic [15:0] d);
    chk({tag, "_we"}, 32'(ram_we_o), 32'd1);
    chk({tag, "_addr"}, 32'(ram_addr_o), 32'(a));
    chk({tag, "_data"}, 32'(ram_data_o), 32'(d));
  endtask

  initial begin
    int w0;
    #2 rst = 1'b1;
    #1;
    chk("rst_core_rst", 32'(core_rst_o), 32'd1);
    chk("rst_ready", 32'(byte_ready_o), 32'd0);
    chk("rst_we", 32'(ram_we_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_csum", 32'(checksum_o), 32'd0);
    #10 rst = 1'b0;
    @(posedge clk); #1;
    byte_valid_i = 1'b1;
    @(posedge clk); #1;
    chk("idle_ready", 32'(byte_ready_o), 32'd0);
    byte_valid_i = 1'b0;

    // good two-word frame, continuous stream
    pulse_start();
    chk("t1_busy", 32'(busy_o), 32'd1);
    send(8'h02, 0); send(8'h00, 0); send(8'h34, 0); send(8'h12, 0);
    write_chk("t1_w0", 16'h0000, 16'h1234);
    send(8'hCD, 0);
    chk("t1_we_single", 32'(ram_we_o), 32'd0);
    send(8'hAB, 0);
    write_chk("t1_w1", 16'h0001, 16'hABCD);
    send(8'h01, 0); send(8'hBE, 0);
    chk("t1_csum", 32'(checksum_o), 32'h0000BE01);
    chk("t1_done", 32'(done_o), 32'd1);
    chk("t1_core_rst", 32'(core_rst_o), 32'd0);
    chk("t1_err", 32'(err_o), 32'd0);
    chk("t1_busy_end", 32'(busy_o), 32'd0);
    chk("t1_we_cnt", 32'(we_cnt), 32'd2);
    chk("done_ready", 32'(byte_ready_o), 32'd0);

    // same frame, wrong checksum
    pulse_start();
    chk("t2_restart_done", 32'(done_o), 32'd0);
    chk("t2_restart_core_rst", 32'(core_rst_o), 32'd1);
    chk("t2_csum_clr", 32'(checksum_o), 32'd0);
    send(8'h02, 0); send(8'h00, 0); send(8'h34, 0); send(8'h12, 0);
    send(8'hCD, 0); send(8'hAB, 0); send(8'h00, 0); send(8'hBE, 0);
    chk("t2_we_cnt", 32'(we_cnt), 32'd4);
    chk("t2_err", 32'(err_o), 32'd1);
    chk("t2_done", 32'(done_o), 32'd0);
    chk("t2_core_rst", 32'(core_rst_o), 32'd1);

    // zero-length header
    pulse_start();
    send(8'h00, 0); send(8'h00, 0);
    chk("t3_err_zero", 32'(err_o), 32'd1);
    chk("t3_no_write", 32'(we_cnt), 32'd4);
    chk("t3_ready", 32'(byte_ready_o), 32'd0);
    // oversize header 0x0401
    pulse_start();
    chk("t3_restart_err", 32'(err_o), 32'd0);
    send(8'h01, 0); send(8'h04, 0);
    chk("t3_err_big", 32'(err_o), 32'd1);
    chk("t3_no_write_big", 32'(we_cnt), 32'd4);

    // wrapping sum, 3-cycle gaps, ignored mid-load start
    pulse_start();
    send(8'h02, 3); send(8'h00, 3); send(8'hFF, 3);
    pulse_start();
    chk("t4_start_ignored_busy", 32'(busy_o), 32'd1);
    send(8'hFF, 0);
    write_chk("t4_w0", 16'h0000, 16'hFFFF);
    repeat (3) @(posedge clk);
    #1;
    send(8'h02, 3); send(8'h00, 0);
    write_chk("t4_w1", 16'h0001, 16'h0002);
    repeat (3) @(posedge clk);
    #1;
    send(8'h01, 3); send(8'h00, 0);
    chk("t4_csum", 32'(checksum_o), 32'h00000001);
    chk("t4_done", 32'(done_o), 32'd1);
    chk("t4_we_cnt", 32'(we_cnt), 32'd6);

    // async reset while in DATA_H
    pulse_start();
    send(8'h01, 0); send(8'h00, 0); send(8'h55, 0);
    w0 = we_cnt;
    byte_i = 8'hAA;
    byte_valid_i = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("t5_core_rst", 32'(core_rst_o), 32'd1);
    chk("t5_ready", 32'(byte_ready_o), 32'd0);
    chk("t5_busy", 32'(busy_o), 32'd0);
    chk("t5_we", 32'(ram_we_o), 32'd0);
    chk("t5_csum", 32'(checksum_o), 32'd0);
    chk("t5_addr", 32'(ram_addr_o), 32'd0);
    chk("t5_data", 32'(ram_data_o), 32'd0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    byte_valid_i = 1'b0;
    chk("t5_no_write", 32'(we_cnt), 32'(w0));
    chk("t5_idle_ready", 32'(byte_ready_o), 32'd0);
    pulse_start();
    send(8'h01, 0); send(8'h00, 0); send(8'h78, 0); send(8'h56, 0);
    write_chk("t5_w0", 16'h0000, 16'h5678);
    send(8'h78, 0); send(8'h56, 0);
    chk("t5_done", 32'(done_o), 32'd1);
    chk("t5_core_rel", 32'(core_rst_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
